// File: rtl/bus_cache_dm_if.sv
// Core-style memory port: one-cycle rd/we strobes, held address, ready level.
// The master drives the request and the slave answers with spo/ready.
interface bus_cache_dm_if;
   logic [31:0] a;
   logic [31:0] d;
   logic        we;
   logic        rd;
   logic [31:0] spo;
   logic        ready;

   modport master (output a, d, we, rd, input spo, ready);
   modport slave  (input a, d, we, rd, output spo, ready);
endinterface

// File: rtl/bus_cache_dm.sv
// Direct-mapped, write-through, no-write-allocate cache with 4-word lines.
// Reads that hit return in the strobe cycle; everything else goes to the bus.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | ready=1, read hits served combinationally
// S_REFILL | four downstream reads filling the line, word 0..3
// S_UNC_RD | single downstream read outside the cacheable window
// S_WR     | single downstream write (write-through)
// S_RESP   | one-cycle response with the requested word
module bus_cache_dm #(
   parameter int unsigned INDEX_BITS = 6,
   parameter logic [31:0] CACHE_BASE = 32'h0000_0000,
   parameter logic [31:0] CACHE_MASK = 32'hf000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            inv,
   bus_cache_dm_if.slave   up,
   bus_cache_dm_if.master  mem
);
   localparam int unsigned LINES    = 1 << INDEX_BITS;
   localparam int unsigned TAG_BITS = 28 - INDEX_BITS;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_REFILL = 3'd1;
   localparam logic [2:0] S_UNC_RD = 3'd2;
   localparam logic [2:0] S_WR     = 3'd3;
   localparam logic [2:0] S_RESP   = 3'd4;

   logic [2:0]            state;
   logic [LINES-1:0]      valid;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [31:0]           data_mem [LINES*4];

   logic [31:2]           a_q;
   logic [1:0]            word_q;
   logic [31:0]           resp_q;
   logic                  inv_pend;

   logic [INDEX_BITS-1:0] idx;
   logic [1:0]            off;
   logic [TAG_BITS-1:0]   tag;
   logic [INDEX_BITS-1:0] a_idx;
   logic [TAG_BITS-1:0]   a_tag;
   logic [1:0]            word_nx;
   logic                  cacheable;
   logic                  strobe;
   logic                  tag_hit;
   logic                  rd_hit;
   logic                  wr_hit;
   logic                  miss_go;
   logic                  beat;
   logic                  last_beat;
   logic                  to_idle;

   assign idx       = up.a[3+INDEX_BITS:4];
   assign off       = up.a[3:2];
   assign tag       = up.a[31:4+INDEX_BITS];
   assign a_idx     = a_q[3+INDEX_BITS:4];
   assign a_tag     = a_q[31:4+INDEX_BITS];
   assign word_nx   = word_q + 2'd1;
   assign cacheable = (up.a & CACHE_MASK) == CACHE_BASE;

   // Strobes are only accepted while idle; a busy cache has ready=0.
   assign strobe    = (state == S_IDLE) && (up.rd || up.we);
   assign tag_hit   = cacheable && valid[idx] && (tag_mem[idx] == tag);
   assign rd_hit    = strobe && up.rd && tag_hit;
   assign wr_hit    = strobe && up.we && tag_hit;
   assign miss_go   = strobe && !rd_hit;
   assign beat      = (state == S_REFILL) && mem.ready;
   assign last_beat = beat && (word_q == 2'd3);
   assign to_idle   = ((state == S_IDLE) && !miss_go) || (state == S_RESP) ||
                      ((state == S_WR) && mem.ready);

   assign up.ready = (state == S_IDLE) ? !miss_go : (state == S_RESP);
   assign up.spo   = rd_hit ? data_mem[{idx, off}] :
                     (state == S_RESP) ? resp_q : 32'h0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         valid    <= '0;
         inv_pend <= 1'b0;
         word_q   <= 2'd0;
         a_q      <= '0;
         resp_q   <= 32'h0;
         mem.a    <= 32'h0;
         mem.d    <= 32'h0;
         mem.rd   <= 1'b0;
         mem.we   <= 1'b0;
      end else begin
         mem.rd <= 1'b0;
         mem.we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (miss_go) begin
                  a_q   <= up.a[31:2];
                  mem.a <= up.a;
                  mem.d <= up.d;
                  if (up.we) begin
                     mem.we <= 1'b1;
                     state  <= S_WR;
                  end else if (cacheable) begin
                     mem.rd <= 1'b1;
                     mem.a  <= {up.a[31:4], 4'b0000};
                     word_q <= 2'd0;
                     state  <= S_REFILL;
                  end else begin
                     mem.rd <= 1'b1;
                     state  <= S_UNC_RD;
                  end
               end
            end
            S_REFILL: begin
               if (mem.ready) begin
                  if (word_q == a_q[3:2]) resp_q <= mem.spo;
                  if (word_q == 2'd3) begin
                     state <= S_RESP;
                  end else begin
                     word_q <= word_nx;
                     mem.rd <= 1'b1;
                     mem.a  <= {a_q[31:4], word_nx, 2'b00};
                  end
               end
            end
            S_UNC_RD: begin
               if (mem.ready) begin
                  resp_q <= mem.spo;
                  state  <= S_RESP;
               end
            end
            S_WR:    if (mem.ready) state <= S_IDLE;
            S_RESP:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase

         if (last_beat) valid[a_idx] <= 1'b1;

         // Invalidate lands on the edge that enters idle, overriding a fresh fill.
         if (to_idle && (inv || inv_pend)) begin
            valid    <= '0;
            inv_pend <= 1'b0;
         end else if (inv) begin
            inv_pend <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         if (wr_hit)    data_mem[{idx, off}]      <= up.d;
         if (beat)      data_mem[{a_idx, word_q}] <= mem.spo;
         if (last_beat) tag_mem[a_idx]            <= a_tag;
      end
   end
endmodule

// File: tb/tb_bus_cache_dm.sv
// Randomized bench for bus_cache_dm: a reference memory plus a valid/tag model
// predict hit/miss timing, downstream traffic and returned data.
module tb_bus_cache_dm;
   typedef struct {
      bit          wr;
      logic [31:0] a;
      logic [31:0] d;
   } txn_t;

   logic clk;
   logic rst;
   logic inv;

   bus_cache_dm_if up_bus();
   bus_cache_dm_if mem_bus();

   bus_cache_dm dut (
      .clk (clk),
      .rst (rst),
      .inv (inv),
      .up  (up_bus),
      .mem (mem_bus)
   );

   int          vecs;
   int          errs;
   int          bus_cnt;
   logic [31:0] mem_m [logic [29:0]];
   bit          mval [64];
   logic [21:0] mtag [64];
   txn_t        expq [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memrd(input logic [31:0] addr);
      if (mem_m.exists(addr[31:2])) return mem_m[addr[31:2]];
      return {addr[31:2], 2'b00} ^ 32'ha5a5_0000;
   endfunction

   function automatic bit is_cch(input logic [31:0] addr);
      return addr[31:28] == 4'h0;
   endfunction

   function automatic bit model_hit(input logic [31:0] addr);
      return is_cch(addr) && mval[addr[9:4]] && (mtag[addr[9:4]] == addr[31:10]);
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 64; i++) mval[i] = 1'b0;
   endtask

   // Bus slave: random 0..2 cycle latency, m_ready may land in the strobe cycle.
   task automatic slave_loop();
      bit          busy;
      int          lat;
      logic [31:0] cur_a;
      txn_t        t;
      busy = 1'b0;
      lat  = 0;
      cur_a = 32'h0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busy = 1'b0;
            mem_bus.ready = 1'b0;
         end else begin
            mem_bus.ready = 1'b0;
            if (mem_bus.rd || mem_bus.we) begin
               bus_cnt++;
               chk("rd_we_excl", {31'h0, mem_bus.rd & mem_bus.we}, 32'h0);
               chk("overlap", {31'h0, busy}, 32'h0);
               if (expq.size() == 0) begin
                  chk("unexpected_bus_addr", mem_bus.a, 32'hffff_ffff);
               end else begin
                  t = expq.pop_front();
                  chk("bus_kind", {31'h0, mem_bus.we}, {31'h0, t.wr});
                  chk("bus_addr", mem_bus.a, t.a);
                  if (t.wr) chk("bus_wdata", mem_bus.d, t.d);
               end
               cur_a = mem_bus.a;
               lat   = $urandom_range(0, 2);
               busy  = 1'b1;
            end
            if (busy) begin
               chk("bus_addr_held", mem_bus.a, cur_a);
               if (lat == 0) begin
                  mem_bus.ready = 1'b1;
                  mem_bus.spo   = memrd(cur_a);
                  busy = 1'b0;
               end else begin
                  lat--;
               end
            end
         end
      end
   endtask

   // Called at posedge+1 with the cache idle; returns at posedge+1 after completion.
   task automatic do_req(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input bit inv_mid, output logic [31:0] got);
      bit          hit;
      bit          done;
      bit          inv_sent;
      logic [31:0] ev;
      txn_t        t;
      hit      = !wr && model_hit(addr);
      ev       = memrd(addr);
      inv_sent = 1'b0;
      got      = 32'h0;
      if (wr) begin
         t.wr = 1'b1; t.a = addr; t.d = wd;
         expq.push_back(t);
         mem_m[addr[31:2]] = wd;
      end else if (!is_cch(addr)) begin
         t.wr = 1'b0; t.a = addr; t.d = 32'h0;
         expq.push_back(t);
      end else if (!hit) begin
         for (int w = 0; w < 4; w++) begin
            t.wr = 1'b0; t.a = {addr[31:4], 4'h0} + 32'(w * 4); t.d = 32'h0;
            expq.push_back(t);
         end
      end
      up_bus.a  = addr;
      up_bus.d  = wd;
      up_bus.rd = !wr;
      up_bus.we = wr;
      @(negedge clk);
      chk("ready_in_strobe", {31'h0, up_bus.ready}, {31'h0, hit});
      if (hit) begin
         got = up_bus.spo;
         chk("hit_data", up_bus.spo, ev);
      end
      @(posedge clk); #1;
      up_bus.rd = 1'b0;
      up_bus.we = 1'b0;
      if (!hit) begin
         done = 1'b0;
         for (int c = 0; c < 64 && !done; c++) begin
            inv = inv_mid && (c == 1);
            if (inv) inv_sent = 1'b1;
            @(negedge clk);
            if (up_bus.ready) begin
               done = 1'b1;
               got  = up_bus.spo;
               if (!wr) chk("resp_data", up_bus.spo, ev);
               chk("bus_done_at_ready", 32'(expq.size()), 32'h0);
            end
            @(posedge clk); #1;
         end
         inv = 1'b0;
         if (!done) chk("ready_timeout", 32'h0, 32'h1);
         if (!wr && is_cch(addr)) begin
            mval[addr[9:4]] = 1'b1;
            mtag[addr[9:4]] = addr[31:10];
         end
      end
      if (inv_sent) model_clear();
   endtask

   task automatic idle_inv();
      inv = 1'b1;
      @(posedge clk); #1;
      inv = 1'b0;
      model_clear();
   endtask

   task automatic rd_cnt(input logic [31:0] addr, input int exp_bus, input string nm,
                         output logic [31:0] got);
      int b0;
      b0 = bus_cnt;
      do_req(1'b0, addr, 32'h0, 1'b0, got);
      chk(nm, 32'(bus_cnt - b0), 32'(exp_bus));
   endtask

   initial begin
      logic [31:0] got;
      logic [31:0] addr;
      int          b0;
      vecs = 0; errs = 0; bus_cnt = 0;
      model_clear();
      rst = 1'b1; inv = 1'b0;
      up_bus.a = 32'h0; up_bus.d = 32'h0; up_bus.rd = 1'b0; up_bus.we = 1'b0;
      mem_bus.ready = 1'b0; mem_bus.spo = 32'h0;
      fork slave_loop(); join_none
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", {31'h0, up_bus.ready}, 32'h1);
      chk("rst_spo",   up_bus.spo, 32'h0);
      chk("rst_m_rd",  {31'h0, mem_bus.rd}, 32'h0);
      chk("rst_m_we",  {31'h0, mem_bus.we}, 32'h0);
      chk("rst_m_a",   mem_bus.a, 32'h0);
      chk("rst_m_d",   mem_bus.d, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      rd_cnt(32'h0000_0104, 4, "refill_0x104_beats", got);
      chk("pin_0x104", got, 32'ha5a5_0104);
      rd_cnt(32'h0000_0108, 0, "hit_0x108_beats", got);
      chk("pin_0x108", got, 32'ha5a5_0108);

      b0 = bus_cnt;
      do_req(1'b1, 32'h0000_0108, 32'hdead_beef, 1'b0, got);
      chk("write_beats", 32'(bus_cnt - b0), 32'h1);
      rd_cnt(32'h0000_0108, 0, "hit_after_write_beats", got);
      chk("pin_write_hit", got, 32'hdead_beef);

      rd_cnt(32'hf000_0010, 1, "unc_rd1_beats", got);
      chk("pin_unc", got, 32'h55a5_0010);
      rd_cnt(32'hf000_0010, 1, "unc_rd2_beats", got);

      rd_cnt(32'h0000_0504, 4, "conflict_0x504_beats", got);
      rd_cnt(32'h0000_0104, 4, "reload_0x104_beats", got);

      b0 = bus_cnt;
      do_req(1'b0, 32'h0000_0200, 32'h0, 1'b1, got);
      chk("inv_refill_beats", 32'(bus_cnt - b0), 32'h4);
      chk("pin_0x200", got, 32'ha5a5_0200);
      rd_cnt(32'h0000_0200, 4, "after_inv_0x200_beats", got);
      rd_cnt(32'h0000_0108, 4, "after_inv_0x108_beats", got);

      // Reset during a refill: line must not survive.
      for (int w = 0; w < 4; w++) expq.push_back('{1'b0, 32'h0000_0340 + 32'(w * 4), 32'h0});
      up_bus.a = 32'h0000_0340; up_bus.rd = 1'b1;
      @(posedge clk); #1; up_bus.rd = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      expq.delete();
      model_clear();
      @(negedge clk);
      chk("midrst_ready", {31'h0, up_bus.ready}, 32'h1);
      chk("midrst_m_rd",  {31'h0, mem_bus.rd}, 32'h0);
      @(posedge clk); #1;
      rd_cnt(32'h0000_0340, 4, "after_rst_0x340_beats", got);
      rd_cnt(32'h0000_0344, 0, "hit_0x344_beats", got);
      idle_inv();
      rd_cnt(32'h0000_0344, 4, "after_idle_inv_beats", got);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 7) == 0)
            addr = 32'hf000_0000 | (32'($urandom_range(0, 15)) << 2);
         else
            addr = {22'($urandom_range(0, 2)), 6'($urandom_range(0, 7)),
                    2'($urandom_range(0, 3)), 2'b00};
         if ($urandom_range(0, 31) == 0) idle_inv();
         do_req($urandom_range(0, 9) == 0, addr, $urandom, $urandom_range(0, 15) == 0, got);
      end

      repeat (3) @(posedge clk);
      chk("final_bus_queue", 32'(expq.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
